program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 165 ++++++++++++++++
 tb/tb_program_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the processor top:
// loader FSM state encoding and the byte order used on the load frame.
package program_loader_pkg;

  // Loader FSM states. The processor top decodes DONE/ERROR from this type.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } loader_state_t;

  // Width of one frame byte.
  localparam int BYTE_W = 8;

  // Multi-byte frame fields (length and every data word) arrive low byte first.
  localparam bit LOW_BYTE_FIRST = 1'b1;

  // Assemble a 16-bit field from two frame bytes in arrival order.
  function automatic logic [15:0] pack_word(input logic [BYTE_W-1:0] first,
                                            input logic [BYTE_W-1:0] second);
    return LOW_BYTE_FIRST ? {second, first} : {first, second};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte source, instruction-memory write port and CPU status signals of the
// program loader, bundled so the top and the bench wire them as one unit.
interface program_loader_if #(
  parameter int l = 16
) ();

  logic         start;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         wr_en;
  logic [l-1:0] wr_addr;
  logic [l-1:0] wr_data;
  logic         cpu_hold;
  logic         done;
  logic         error;

  // Side that feeds bytes and consumes the write port and status.
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  // The loader itself.
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

endinterface

// File: rtl/program_loader.sv
// Serial program loader. Receives a frame of LEN_LO, LEN_HI, N words (low
// byte first) and an XOR checksum byte, writes each word into instruction
// memory through a one-cycle write strobe, and holds the CPU until a frame
// completes with a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int l = 16,
  parameter int a = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  program_loader_if.slave bus
);

  // Word counter is one bit wider than the address so N = 2^a does not wrap.
  localparam int          CW        = a + 1;
  localparam logic [31:0] MAX_WORDS = 32'd1 << a;

  loader_state_t state_reg, state_next;

  logic [7:0]    xor_reg, xor_next;
  logic [7:0]    len_lo_reg, len_lo_next;
  logic [7:0]    low_reg, low_next;
  logic [CW-1:0] n_reg, n_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          wr_en_reg, wr_en_next;
  logic [l-1:0]  wr_addr_reg, wr_addr_next;
  logic [l-1:0]  wr_data_reg, wr_data_next;

  logic          byte_ready;
  logic          xfer;
  logic [15:0]   len_word;
  logic [31:0]   len_ext;

  // Ready is a pure function of state, so it never depends on byte_valid.
  assign byte_ready = (state_reg == LEN_LO)  || (state_reg == LEN_HI) ||
                      (state_reg == DATA_LO) || (state_reg == DATA_HI) ||
                      (state_reg == CHECK);
  assign xfer       = byte_ready & bus.byte_valid;

  // Length as it will stand once the high byte on the bus is accepted.
  assign len_word   = pack_word(len_lo_reg, bus.byte_data);
  assign len_ext    = {16'd0, len_word};
  assign cnt_inc    = cnt_reg + {{a{1'b0}}, 1'b1};

  // Next-state and datapath decode; every target is defaulted first.
  always_comb begin
    state_next   = state_reg;
    xor_next     = xor_reg;
    len_lo_next  = len_lo_reg;
    low_next     = low_reg;
    n_next       = n_reg;
    cnt_next     = cnt_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;

    // Every accepted byte, length and checksum included, folds into the XOR.
    if (xfer) begin
      xor_next = xor_reg ^ bus.byte_data;
    end

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (bus.start) begin
          state_next = LEN_LO;
          xor_next   = 8'd0;
          cnt_next   = '0;
        end
      end

      LEN_LO: begin
        if (xfer) begin
          len_lo_next = bus.byte_data;
          state_next  = LEN_HI;
        end
      end

      LEN_HI: begin
        if (xfer) begin
          if (len_ext == 32'd0) begin
            state_next = CHECK;
          end else if (len_ext > MAX_WORDS) begin
            // Oversize frame: abort before any word is written.
            state_next = ERROR;
          end else begin
            n_next     = len_ext[CW-1:0];
            state_next = DATA_LO;
          end
        end
      end

      DATA_LO: begin
        if (xfer) begin
          low_next   = bus.byte_data;
          state_next = DATA_HI;
        end
      end

      DATA_HI: begin
        if (xfer) begin
          // The write strobe fires on the cycle after the high byte arrives.
          wr_en_next   = 1'b1;
          wr_addr_next = l'(cnt_reg[a-1:0]);
          wr_data_next = l'(pack_word(low_reg, bus.byte_data));
          cnt_next     = cnt_inc;
          state_next   = (cnt_inc == n_reg) ? CHECK : DATA_LO;
        end
      end

      CHECK: begin
        if (xfer) begin
          // Compare against the XOR of everything before the checksum byte.
          state_next = (bus.byte_data == xor_reg) ? DONE : ERROR;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // FSM state register; reset lands in IDLE at once, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers; reset also drops a half-received word and a pending strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_reg     <= 8'd0;
      len_lo_reg  <= 8'd0;
      low_reg     <= 8'd0;
      n_reg       <= '0;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      xor_reg     <= xor_next;
      len_lo_reg  <= len_lo_next;
      low_reg     <= low_next;
      n_reg       <= n_next;
      cnt_reg     <= cnt_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Status decodes straight from state; the CPU runs only after a good load.
  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = wr_en_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.cpu_hold   = (state_reg != DONE);
  assign bus.done       = (state_reg == DONE);
  assign bus.error      = (state_reg == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/empty/bad-checksum/oversize frames,
// asynchronous reset mid-word, gapped byte stream with a stray start, and a
// maximum-length frame.
module tb_program_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  program_loader_if #(.l(16)) bus ();

  program_loader #(.l(16), .a(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Observed writes and strobe-width violations, sampled on the falling edge.
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wide_pulses = 0;
  logic        wr_en_prev  = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      if (wr_en_prev) wide_pulses++;
    end
    wr_en_prev = (bus.wr_en === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte from just after a rising edge and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 20; t++) begin
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  // Send a frame; optional random idle gaps and a stray start before byte start_at.
  task automatic send_frame(input logic [7:0] fr[$], input int max_gap, input int start_at);
    bit ok;
    for (int i = 0; i < fr.size(); i++) begin
      if (max_gap > 0) begin
        bus.byte_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk); #1;
        end
      end
      if (i == start_at) begin
        bus.byte_valid = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      send_byte(fr[i], ok);
      if (!ok) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Expect exactly the two words 0x1234 @0 and 0x5678 @1.
  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"}, wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk({tag, "_a0"}, wa_q[0], 32'h0);
      chk({tag, "_d0"}, wd_q[0], 32'h1234);
      chk({tag, "_a1"}, wa_q[1], 32'h1);
      chk({tag, "_d1"}, wd_q[1], 32'h5678);
    end
  endtask

  initial begin
    // XOR over 02 00 34 12 78 56 is 0x0A; 0x09 is a deliberately bad checksum.
    logic [7:0] good_fr[$]  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    logic [7:0] bad_fr[$]   = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
    logic [7:0] empty_fr[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] over_fr[$]  = '{8'h01, 8'h01};
    logic [7:0] part_fr[$]  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
    logic [7:0] big_fr[$];
    logic [7:0] sum;
    int c0;
    int bad;

    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset: outputs take their reset values without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.byte_ready, 32'd0);
    chk("rst_wren",  bus.wr_en,      32'd0);
    chk("rst_waddr", bus.wr_addr,    32'd0);
    chk("rst_wdata", bus.wr_data,    32'd0);
    chk("rst_done",  bus.done,       32'd0);
    chk("rst_error", bus.error,      32'd0);
    chk("rst_hold",  bus.cpu_hold,   32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle_hold",  bus.cpu_hold,   32'd1);
    chk("idle_ready", bus.byte_ready, 32'd0);

    // Good frame, back-to-back: seven bytes in seven cycles.
    clear_writes();
    pulse_start();
    c0 = cyc;
    send_frame(good_fr, 0, -1);
    chk("good_cycles", cyc - c0, 32'd7);
    chk("good_done",   bus.done,     32'd1);
    chk("good_hold",   bus.cpu_hold, 32'd0);
    chk("good_error",  bus.error,    32'd0);
    chk("good_ready",  bus.byte_ready, 32'd0);
    check_two_writes("good");

    // Empty frame restarted from DONE.
    clear_writes();
    pulse_start();
    chk("empty_restart_hold", bus.cpu_hold, 32'd1);
    send_frame(empty_fr, 0, -1);
    chk("empty_done", bus.done, 32'd1);
    chk("empty_nwr",  wa_q.size(), 32'd0);

    // Bad checksum: words stay written, CPU stays held.
    clear_writes();
    pulse_start();
    send_frame(bad_fr, 0, -1);
    chk("bad_error", bus.error,    32'd1);
    chk("bad_hold",  bus.cpu_hold, 32'd1);
    chk("bad_done",  bus.done,     32'd0);
    check_two_writes("bad");

    // Oversize length 0x0101 aborts right after the length bytes.
    clear_writes();
    pulse_start();
    send_frame(over_fr, 0, -1);
    chk("over_error", bus.error,      32'd1);
    chk("over_ready", bus.byte_ready, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("over_nwr", wa_q.size(), 32'd0);

    // Asynchronous reset between the two bytes of word 1.
    clear_writes();
    pulse_start();
    send_frame(part_fr, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.byte_ready, 32'd0);
    chk("mid_rst_hold",  bus.cpu_hold,   32'd1);
    chk("mid_rst_error", bus.error,      32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_nwr",   wa_q.size(),    32'd1);
    chk("mid_idle_hold", bus.cpu_hold,   32'd1);
    chk("mid_idle_rdy",  bus.byte_ready, 32'd0);
    clear_writes();
    pulse_start();
    send_frame(good_fr, 0, -1);
    chk("mid_reload_done", bus.done, 32'd1);
    check_two_writes("mid_reload");

    // Gapped byte stream with a stray start in the middle of the data.
    clear_writes();
    pulse_start();
    send_frame(good_fr, 3, 3);
    chk("gap_done",  bus.done,     32'd1);
    chk("gap_hold",  bus.cpu_hold, 32'd0);
    check_two_writes("gap");

    // Largest legal frame: 256 words, last address 255.
    big_fr.push_back(8'h00);
    big_fr.push_back(8'h01);
    for (int i = 0; i < 256; i++) begin
      big_fr.push_back(8'(i));
      big_fr.push_back(~8'(i));
    end
    sum = 8'h00;
    foreach (big_fr[i]) sum ^= big_fr[i];
    big_fr.push_back(sum);
    clear_writes();
    pulse_start();
    send_frame(big_fr, 0, -1);
    chk("big_done", bus.done,    32'd1);
    chk("big_nwr",  wa_q.size(), 32'd256);
    bad = 0;
    foreach (wa_q[i]) begin
      if (wa_q[i] !== 16'(i) || wd_q[i] !== {~8'(i), 8'(i)}) bad++;
    end
    chk("big_bad_words", bad, 32'd0);
    if (wa_q.size() > 0) chk("big_last_addr", wa_q[wa_q.size()-1], 32'd255);

    chk("wren_one_cycle", wide_pulses, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
